// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter among N_REQ requesters.
// Optional macro SHIFT_ARB_PRIO_EN makes requester 0 a fixed high-priority requester.
module shift_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 2,
    parameter int SH_LAT  = 1,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ*SHAMT_W-1:0]   req_shamt,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           sh_data_in,
    output logic [SHAMT_W-1:0]         sh_shift_amt,
    input  logic [WIDTH-1:0]           sh_data_out,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int CNT_W = (SH_LAT > 1) ? $clog2(SH_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       last_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [WIDTH-1:0]      cap_data_p0;
    logic [SHAMT_W-1:0]    cap_shamt_p0;
    logic [ID_W-1:0]       cap_id_p0;

    logic                  rsp_vld_p1;
    logic [WIDTH-1:0]      rsp_data_p1;
    logic [ID_W-1:0]       rsp_id_p1;

    logic                  gnt_any;
    logic [ID_W-1:0]       gnt_id;
    logic                  upd_last;
    logic [N_REQ-1:0]      gnt_vec;
    logic                  do_grant;
    logic                  shift_done;

    // First valid index strictly after last, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (v[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        gnt_any = |req_valid;
`ifdef SHIFT_ARB_PRIO_EN
        if (req_valid[0]) begin
            gnt_id   = '0;
            upd_last = 1'b0;
        end else begin
            gnt_id   = rr_pick(req_valid, last_q);
            upd_last = 1'b1;
        end
`else
        gnt_id   = rr_pick(req_valid, last_q);
        upd_last = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_vec = '0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    gnt_vec[gnt_id] = 1'b1;
                    state_d         = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                if (rsp_vld_p1 && rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign do_grant   = (state_q == IDLE) && gnt_any;
    assign shift_done = (state_q == SHIFT) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= ID_W'(N_REQ - 1);
            cnt_q      <= '0;
            rsp_vld_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_grant) begin
                cnt_q <= CNT_W'(SH_LAT - 1);
                if (upd_last) last_q <= gnt_id;
            end else if ((state_q == SHIFT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (shift_done) begin
                rsp_vld_p1 <= 1'b1;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_vld_p1 <= 1'b0;
            end
        end
    end

    // Stage p0: operand capture, held on the shifter inputs until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_data_p0  <= '0;
            cap_shamt_p0 <= '0;
            cap_id_p0    <= '0;
        end else if (do_grant) begin
            cap_data_p0  <= req_data[int'(gnt_id)*WIDTH +: WIDTH];
            cap_shamt_p0 <= req_shamt[int'(gnt_id)*SHAMT_W +: SHAMT_W];
            cap_id_p0    <= gnt_id;
        end
    end

    // Stage p1: shifter result sampled after SH_LAT cycles of stable inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_p1 <= '0;
            rsp_id_p1   <= '0;
        end else if (shift_done) begin
            rsp_data_p1 <= sh_data_out;
            rsp_id_p1   <= cap_id_p0;
        end
    end

    // The grant is combinational, so it is masked while reset is asserted.
    assign req_ready    = gnt_vec & {N_REQ{rst_n}};
    assign sh_data_in   = cap_data_p0;
    assign sh_shift_amt = cap_shamt_p0;
    assign rsp_valid    = rsp_vld_p1;
    assign rsp_data     = rsp_data_p1;
    assign rsp_id       = rsp_id_p1;
    assign busy         = (state_q != IDLE);

endmodule
